mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control unit for the MIPS CPU: a state machine that sequences one instruction across FETCH/DECODE/EXEC/MEM/WB cycles, driving the existing datapath (PC, IR, register file, ALU, NPC, EXT) and a single unified memory port shared between instruction fetch and data access via a req/ack handshake. It sits between the IR (Op/Funct), the ALU (Zero) and the memory port. It replaces the single-cycle decode-to-control path for the multi-cycle build.

## Interface
- MEM_TIMEOUT, 255: maximum cycles `mem_req` may wait for `mem_ack` (0 = no timeout); counter width is 8 bits.
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- Op  in  6  IR[31:26], valid from DECODE onward
- Funct  in  6  IR[5:0]
- Zero  in  1  ALU zero flag, combinational, same cycle
- mem_ack  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  write qualifier for `mem_req`
- IRWrite, PCWrite, RegWrite  out  1 each  register/PC write enables
- EXTOp  out  1  1 = sign extend
- ALUSrcA  out  1  1 = shamt, 0 = rs
- ALUSrcB  out  1  1 = extended immediate, 0 = rt
- ALUOp  out  5  codebase ALU encoding (NOP 0, ADD 1, SUB 2, AND 3, OR 4, SLT 5, SLTU 6, NOR 7, SLL 8, SRL 9, SRA 10, SLLV 11, SRLV 12, LUI 13, XOR 15, SRAV 16)
- NPCOp  out  2  00 PC+4, 01 branch, 10 jump, 11 jr
- GPRSel  out  2  00 rd, 01 rt, 10 $31
- WDSel  out  2  00 ALU, 01 MEM, 10 PC
- state  out  4  current state (debug)
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal  out  1  one-cycle pulse in DECODE for an unsupported Op/Funct
- bus_err  out  1  one-cycle pulse on memory timeout
- halted  out  1  high in HALT

## Operation
- Supported instructions: add, addu, sub, subu, and, or, nor, xor, slt, sltu, sll, srl, sra, sllv, srlv, srav, jr, jalr, addi, andi, ori, slti, lui, lw, sw, beq, bne, j, jal. EXTOp=1 for addi, slti, lw, sw, beq, bne.
- States and encoding (outputs not listed are 0):
  - FETCH 0: mem_req=1, IorD=0. On ack: IRWrite=1, PCWrite=1, NPCOp=00 -> DECODE.
  - DECODE 1: no enables. R-ALU/I-ALU -> EXEC; lw/sw -> MEM_ADDR; beq/bne -> BRANCH; j/jal/jr/jalr -> JUMP; otherwise `illegal`=1, instr_done=1 -> FETCH.
  - EXEC 2: ALUOp/ALUSrcA/ALUSrcB per instruction; ALUSrcA=1 only for sll/srl/sra. -> WB_ALU.
  - WB_ALU 3: ALU controls held; RegWrite=1, WDSel=00, GPRSel=00 (R-type) or 01 (I-type); instr_done -> FETCH.
  - MEM_ADDR 4: ALUOp=ADD, ALUSrcB=1. lw -> MEM_RD, sw -> MEM_WR.
  - MEM_RD 5: ALU controls held; mem_req=1, IorD=1. On ack -> WB_MEM.
  - WB_MEM 6: RegWrite=1, WDSel=01, GPRSel=01; instr_done -> FETCH.
  - MEM_WR 7: ALU controls held; mem_req=1, IorD=1, MemWrite=1. On ack: instr_done -> FETCH.
  - BRANCH 8: ALUOp=SUB, ALUSrcB=0, NPCOp=01, PCWrite=(beq&Zero)|(bne&~Zero); instr_done -> FETCH.
  - JUMP 9: PCWrite=1; NPCOp=10 for j/jal, 11 for jr/jalr. For jal/jalr: RegWrite=1, WDSel=10, GPRSel=10. instr_done -> FETCH.
  - HALT 10: halted=1, all else 0; exit only by reset.
- Wait counter: cleared on entry to any memory state and on ack; increments each cycle `mem_req` is high without ack. If MEM_TIMEOUT≠0 and count reaches MEM_TIMEOUT without ack, assert bus_err and go to HALT on the next edge.
- `mem_ack` outside memory states is ignored.

## Timing
- Outputs are combinational from the registered state (plus Op/Funct/Zero). While rstn=0, state=FETCH, counter=0, and every output is forced to 0, including mem_req.
- First mem_req appears in the first cycle after rstn deasserts.
- Latency with zero-wait memory (ack in the first request cycle): ALU ops 4 cycles, lw 5, sw 4, branch/jump 3, illegal 2.
- Each wait state adds 1 cycle. mem_req, IorD and MemWrite stay stable until the ack cycle.
- Reset during a memory access drops mem_req asynchronously; the memory must abandon the access.

## Test plan
- Reset release, then `addu` (Op=0, Funct=0x21) with ack on the first request -> states 0,1,2,3. In state 3: RegWrite=1, GPRSel=00, ALUOp=1. instr_done in cycle 4.
- `lw` (Op=0x23) with 3 wait cycles on each access -> FETCH held 4 cycles with IorD=0, MEM_RD held 4 cycles with IorD=1, WB_MEM: WDSel=01, GPRSel=01; 11 cycles total.
- `beq` (Op=0x04) with Zero=1 -> PCWrite=1, NPCOp=01. `bne` (Op=0x05) with Zero=1 -> PCWrite=0.
- `jal` (Op=0x03) -> JUMP with PCWrite=1, NPCOp=10, RegWrite=1, WDSel=10, GPRSel=10. `jr` (Funct=0x08) -> NPCOp=11, RegWrite=0.
- Op=0x3F -> illegal and instr_done pulse in DECODE, back to FETCH next cycle; `sll` -> ALUSrcA=1, ALUOp=8.
- MEM_TIMEOUT=4 with no ack in FETCH -> bus_err after 4 waiting cycles, then HALT with halted=1 and mem_req=0. rstn low during a MEM_WR wait -> mem_req=0 immediately, state=0.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// Unified memory port between mc_ctrl and the shared instruction/data memory.
// master drives mem_req/IorD/MemWrite, slave answers with mem_ack.
interface mc_ctrl_if;
    logic mem_req;
    logic mem_ack;
    logic IorD;
    logic MemWrite;

    modport master (
        output mem_req,
        output IorD,
        output MemWrite,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  IorD,
        input  MemWrite,
        output mem_ack
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing over a
// shared req/ack memory port (mem), with wait-state timeout into HALT.
// Ports: clk, rstn, Op/Funct/Zero in; datapath enables/selects, state,
// instr_done, illegal, bus_err, halted out. All outputs are 0 while rstn=0.
module mc_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    mc_ctrl_if.master  mem,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       EXTOp,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [4:0] ALUOp,
    output logic [1:0] NPCOp,
    output logic [1:0] GPRSel,
    output logic [1:0] WDSel,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal,
    output logic       bus_err,
    output logic       halted
);
    typedef enum logic [3:0] {
        S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC = 4'd2,
        S_WB_ALU = 4'd3, S_MEM_ADDR = 4'd4, S_MEM_RD = 4'd5,
        S_WB_MEM = 4'd6, S_MEM_WR = 4'd7, S_BRANCH = 4'd8,
        S_JUMP = 4'd9, S_HALT = 4'd10
    } state_e;

    localparam logic [4:0] A_ADD = 5'd1, A_SUB = 5'd2;
    localparam logic [7:0] TO = 8'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    logic       r_alu, i_alu, ld, st, br, jmp;
    logic       link, jreg, shamt, ext_op, is_beq;
    logic [4:0] alu_op;

    always_comb begin
        r_alu = 1'b0; i_alu = 1'b0; ld = 1'b0; st = 1'b0;
        br = 1'b0; jmp = 1'b0; link = 1'b0; jreg = 1'b0;
        shamt = 1'b0; ext_op = 1'b0; is_beq = 1'b0;
        alu_op = 5'd0;
        case (Op)
            6'h00: begin
                r_alu = 1'b1;
                case (Funct)
                    6'h20, 6'h21: alu_op = 5'd1;
                    6'h22, 6'h23: alu_op = 5'd2;
                    6'h24: alu_op = 5'd3;
                    6'h25: alu_op = 5'd4;
                    6'h26: alu_op = 5'd15;
                    6'h27: alu_op = 5'd7;
                    6'h2A: alu_op = 5'd5;
                    6'h2B: alu_op = 5'd6;
                    6'h00: begin alu_op = 5'd8;  shamt = 1'b1; end
                    6'h02: begin alu_op = 5'd9;  shamt = 1'b1; end
                    6'h03: begin alu_op = 5'd10; shamt = 1'b1; end
                    6'h04: alu_op = 5'd11;
                    6'h06: alu_op = 5'd12;
                    6'h07: alu_op = 5'd16;
                    6'h08: begin r_alu = 1'b0; jmp = 1'b1; jreg = 1'b1; end
                    6'h09: begin
                        r_alu = 1'b0; jmp = 1'b1;
                        jreg = 1'b1; link = 1'b1;
                    end
                    default: r_alu = 1'b0;
                endcase
            end
            6'h08: begin i_alu = 1'b1; alu_op = 5'd1; ext_op = 1'b1; end
            6'h0C: begin i_alu = 1'b1; alu_op = 5'd3; end
            6'h0D: begin i_alu = 1'b1; alu_op = 5'd4; end
            6'h0A: begin i_alu = 1'b1; alu_op = 5'd5; ext_op = 1'b1; end
            6'h0F: begin i_alu = 1'b1; alu_op = 5'd13; end
            6'h23: begin ld = 1'b1; ext_op = 1'b1; end
            6'h2B: begin st = 1'b1; ext_op = 1'b1; end
            6'h04: begin br = 1'b1; ext_op = 1'b1; is_beq = 1'b1; end
            6'h05: begin br = 1'b1; ext_op = 1'b1; end
            6'h02: jmp = 1'b1;
            6'h03: begin jmp = 1'b1; link = 1'b1; end
            default: ;
        endcase
    end

    logic       req_c, iord_c, mw_c, irw_c, pcw_c, rw_c;
    logic       ext_c, asa_c, asb_c, done_c, ill_c, berr_c, halt_c;
    logic [4:0] alu_c;
    logic [1:0] npc_c, gsel_c, wd_c;

    always_comb begin
        state_d = state_q;
        req_c = 1'b0; iord_c = 1'b0; mw_c = 1'b0; irw_c = 1'b0;
        pcw_c = 1'b0; rw_c = 1'b0; ext_c = 1'b0; asa_c = 1'b0;
        asb_c = 1'b0; done_c = 1'b0; ill_c = 1'b0; berr_c = 1'b0;
        halt_c = 1'b0; alu_c = 5'd0; npc_c = 2'b00;
        gsel_c = 2'b00; wd_c = 2'b00;
        unique case (state_q)
            S_FETCH: begin
                req_c = 1'b1;
                if (mem.mem_ack) begin
                    irw_c = 1'b1; pcw_c = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (r_alu | i_alu)  state_d = S_EXEC;
                else if (ld | st)   state_d = S_MEM_ADDR;
                else if (br)        state_d = S_BRANCH;
                else if (jmp)       state_d = S_JUMP;
                else begin
                    ill_c = 1'b1; done_c = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC, S_WB_ALU: begin
                alu_c = alu_op; asa_c = shamt;
                asb_c = i_alu; ext_c = ext_op;
                if (state_q == S_EXEC) state_d = S_WB_ALU;
                else begin
                    rw_c = 1'b1; done_c = 1'b1;
                    gsel_c = i_alu ? 2'b01 : 2'b00;
                    state_d = S_FETCH;
                end
            end
            S_MEM_ADDR: begin
                alu_c = A_ADD; asb_c = 1'b1; ext_c = ext_op;
                state_d = ld ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD, S_MEM_WR: begin
                alu_c = A_ADD; asb_c = 1'b1; ext_c = ext_op;
                req_c = 1'b1; iord_c = 1'b1;
                mw_c = (state_q == S_MEM_WR);
                if (mem.mem_ack) begin
                    done_c = mw_c;
                    state_d = mw_c ? S_FETCH : S_WB_MEM;
                end
            end
            S_WB_MEM: begin
                rw_c = 1'b1; wd_c = 2'b01; gsel_c = 2'b01;
                done_c = 1'b1; state_d = S_FETCH;
            end
            S_BRANCH: begin
                alu_c = A_SUB; npc_c = 2'b01; ext_c = ext_op;
                pcw_c = is_beq ? Zero : ~Zero;
                done_c = 1'b1; state_d = S_FETCH;
            end
            S_JUMP: begin
                pcw_c = 1'b1;
                npc_c = jreg ? 2'b11 : 2'b10;
                if (link) begin
                    rw_c = 1'b1; wd_c = 2'b10; gsel_c = 2'b10;
                end
                done_c = 1'b1; state_d = S_FETCH;
            end
            S_HALT: halt_c = 1'b1;
            default: state_d = S_FETCH;
        endcase
        // Timeout fires only while still waiting; an ack in the same cycle wins.
        if (MEM_TIMEOUT != 0 && req_c && !mem.mem_ack && cnt_q == TO) begin
            berr_c = 1'b1;
            state_d = S_HALT;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q || mem.mem_ack) cnt_d = 8'd0;
        else if (req_c && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_FETCH;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset masks every output combinationally so an in-flight access drops.
    assign mem.mem_req  = req_c & rstn;
    assign mem.IorD     = iord_c & rstn;
    assign mem.MemWrite = mw_c & rstn;
    assign IRWrite      = irw_c & rstn;
    assign PCWrite      = pcw_c & rstn;
    assign RegWrite     = rw_c & rstn;
    assign EXTOp        = ext_c & rstn;
    assign ALUSrcA      = asa_c & rstn;
    assign ALUSrcB      = asb_c & rstn;
    assign ALUOp        = rstn ? alu_c : 5'd0;
    assign NPCOp        = rstn ? npc_c : 2'b00;
    assign GPRSel       = rstn ? gsel_c : 2'b00;
    assign WDSel        = rstn ? wd_c : 2'b00;
    assign state        = rstn ? state_q : 4'd0;
    assign instr_done   = done_c & rstn;
    assign illegal      = ill_c & rstn;
    assign bus_err      = berr_c & rstn;
    assign halted       = halt_c & rstn;
endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: builds an expected per-cycle trace from the
// instruction-level rules, then drives and compares cycle by cycle.
module tb_mc_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic [5:0] Op, Funct;
    logic       Zero;
    logic       IRWrite, PCWrite, RegWrite, EXTOp, ALUSrcA, ALUSrcB;
    logic [4:0] ALUOp;
    logic [1:0] NPCOp, GPRSel, WDSel;
    logic [3:0] state;
    logic       instr_done, illegal, bus_err, halted;

    mc_ctrl_if mif();

    mc_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero),
        .mem(mif.master),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .EXTOp(EXTOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .NPCOp(NPCOp), .GPRSel(GPRSel), .WDSel(WDSel),
        .state(state), .instr_done(instr_done), .illegal(illegal),
        .bus_err(bus_err), .halted(halted)
    );

    typedef struct packed {
        logic [3:0] st;
        logic req, iord, mw, irw, pcw, rw, ext, asa, asb;
        logic [4:0] alu;
        logic [1:0] npc, gsel, wd;
        logic done, ill, berr, halt;
    } out_t;

    typedef struct {
        string      tag;
        logic       rn;
        logic [5:0] op, fn;
        logic       z, ack;
        out_t       exp;
    } rec_t;

    rec_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    function automatic void push(string tag, logic rn, logic [5:0] op,
                                 logic [5:0] fn, logic z, logic ack, out_t o);
        rec_t r;
        r.tag = tag; r.rn = rn; r.op = op; r.fn = fn;
        r.z = z; r.ack = ack; r.exp = o;
        q.push_back(r);
    endfunction

    // Instruction classes: 0 illegal, 1 R-ALU, 2 I-ALU, 3 lw, 4 sw, 5 branch, 6 jump
    function automatic void info(input logic [5:0] op, fn, output int cls,
                                 output logic [4:0] alu, output logic sh,
                                 output logic ext, output logic lnk,
                                 output logic jr, output logic beq);
        cls = 0; alu = 0; sh = 0; ext = 0; lnk = 0; jr = 0; beq = 0;
        case (op)
            6'h00: begin
                cls = 1;
                case (fn)
                    6'h20, 6'h21: alu = 1;
                    6'h22, 6'h23: alu = 2;
                    6'h24: alu = 3;
                    6'h25: alu = 4;
                    6'h26: alu = 15;
                    6'h27: alu = 7;
                    6'h2A: alu = 5;
                    6'h2B: alu = 6;
                    6'h00: begin alu = 8; sh = 1; end
                    6'h02: begin alu = 9; sh = 1; end
                    6'h03: begin alu = 10; sh = 1; end
                    6'h04: alu = 11;
                    6'h06: alu = 12;
                    6'h07: alu = 16;
                    6'h08: begin cls = 6; jr = 1; end
                    6'h09: begin cls = 6; jr = 1; lnk = 1; end
                    default: cls = 0;
                endcase
            end
            6'h08: begin cls = 2; alu = 1; ext = 1; end
            6'h0C: begin cls = 2; alu = 3; end
            6'h0D: begin cls = 2; alu = 4; end
            6'h0A: begin cls = 2; alu = 5; ext = 1; end
            6'h0F: begin cls = 2; alu = 13; end
            6'h23: begin cls = 3; ext = 1; end
            6'h2B: begin cls = 4; ext = 1; end
            6'h04: begin cls = 5; ext = 1; beq = 1; end
            6'h05: begin cls = 5; ext = 1; end
            6'h02: cls = 6;
            6'h03: begin cls = 6; lnk = 1; end
            default: cls = 0;
        endcase
    endfunction

    // Appends the expected trace of one instruction; returns its cycle count.
    function automatic int build(string t, logic [5:0] op, logic [5:0] fn,
                                 logic z, int w1, int w2, logic nz);
        int cls; logic [4:0] alu; logic sh, ext, lnk, jr, beq;
        out_t o;
        int n0 = q.size();
        info(op, fn, cls, alu, sh, ext, lnk, jr, beq);
        for (int w = 0; w <= w1; w++) begin
            o = '0; o.req = 1;
            if (w == w1) begin o.irw = 1; o.pcw = 1; end
            push(t, 1, op, fn, z, w == w1, o);
        end
        o = '0; o.st = 1;
        if (cls == 0) begin o.ill = 1; o.done = 1; end
        push(t, 1, op, fn, z, nz, o);
        case (cls)
            1, 2: begin
                o = '0; o.st = 2; o.alu = alu; o.asa = sh;
                o.asb = (cls == 2); o.ext = ext;
                push(t, 1, op, fn, z, nz, o);
                o.st = 3; o.rw = 1; o.done = 1;
                o.gsel = (cls == 2) ? 2'b01 : 2'b00;
                push(t, 1, op, fn, z, 1'b0, o);
            end
            3, 4: begin
                o = '0; o.st = 4; o.alu = 1; o.asb = 1; o.ext = 1;
                push(t, 1, op, fn, z, nz, o);
                for (int w = 0; w <= w2; w++) begin
                    o = '0; o.st = (cls == 3) ? 4'd5 : 4'd7;
                    o.alu = 1; o.asb = 1; o.ext = 1;
                    o.req = 1; o.iord = 1; o.mw = (cls == 4);
                    o.done = (cls == 4) && (w == w2);
                    push(t, 1, op, fn, z, w == w2, o);
                end
                if (cls == 3) begin
                    o = '0; o.st = 6; o.rw = 1; o.wd = 1;
                    o.gsel = 1; o.done = 1;
                    push(t, 1, op, fn, z, nz, o);
                end
            end
            5: begin
                o = '0; o.st = 8; o.alu = 2; o.npc = 1; o.ext = 1;
                o.pcw = beq ? z : ~z; o.done = 1;
                push(t, 1, op, fn, z, nz, o);
            end
            6: begin
                o = '0; o.st = 9; o.pcw = 1; o.done = 1;
                o.npc = jr ? 2'b11 : 2'b10;
                if (lnk) begin o.rw = 1; o.wd = 2; o.gsel = 2; end
                push(t, 1, op, fn, z, nz, o);
            end
            default: ;
        endcase
        return q.size() - n0;
    endfunction

    function automatic void rst_cycles(int n);
        for (int i = 0; i < n; i++) push("rst", 0, 6'h00, 6'h21, 0, 0, '0);
    endfunction

    initial begin
        int   c, b;
        out_t o, act;
        rstn = 0; Op = 0; Funct = 0; Zero = 0; mif.mem_ack = 0;

        rst_cycles(2);
        b = q.size();
        c = build("addu", 6'h00, 6'h21, 0, 0, 0, 0);
        chk("len_addu", c, 4);
        chk("addu_wb_alu", q[b+3].exp.alu, 1);
        chk("addu_wb_rw", {q[b+3].exp.rw, q[b+3].exp.gsel}, 3'b100);
        c = build("lw_w3", 6'h23, 6'h00, 0, 3, 3, 1);
        chk("len_lw_w3", c, 11);
        c = build("sw", 6'h2B, 6'h00, 0, 0, 0, 0);
        chk("len_sw", c, 4);
        c = build("beq_z1", 6'h04, 6'h00, 1, 0, 0, 1);
        chk("len_beq", c, 3);
        b = q.size();
        c = build("bne_z1", 6'h05, 6'h00, 1, 0, 0, 0);
        chk("bne_z1_pcw", q[b+2].exp.pcw, 0);
        c = build("bne_z0", 6'h05, 6'h00, 0, 1, 0, 0);
        c = build("beq_z0", 6'h04, 6'h00, 0, 0, 0, 0);
        c = build("jal", 6'h03, 6'h00, 0, 0, 0, 1);
        c = build("jr", 6'h00, 6'h08, 0, 0, 0, 0);
        c = build("jalr", 6'h00, 6'h09, 0, 0, 0, 0);
        c = build("j", 6'h02, 6'h00, 0, 2, 0, 0);
        b = q.size();
        c = build("ill_op", 6'h3F, 6'h00, 0, 0, 0, 1);
        chk("len_ill", c, 2);
        chk("ill_flags", {q[b+1].exp.ill, q[b+1].exp.done}, 2'b11);
        c = build("ill_fn", 6'h00, 6'h3F, 0, 0, 0, 0);
        c = build("sll", 6'h00, 6'h00, 0, 0, 0, 1);
        c = build("sra", 6'h00, 6'h03, 0, 0, 0, 0);
        c = build("srav", 6'h00, 6'h07, 0, 0, 0, 0);
        c = build("xor", 6'h00, 6'h26, 0, 0, 0, 0);
        c = build("nor", 6'h00, 6'h27, 0, 0, 0, 0);
        c = build("sltu", 6'h00, 6'h2B, 0, 0, 0, 0);
        c = build("sub", 6'h00, 6'h22, 0, 0, 0, 0);
        c = build("addi", 6'h08, 6'h00, 0, 0, 0, 1);
        c = build("andi", 6'h0C, 6'h00, 0, 0, 0, 0);
        c = build("ori", 6'h0D, 6'h00, 0, 0, 0, 0);
        c = build("slti", 6'h0A, 6'h00, 0, 0, 0, 0);
        c = build("lui", 6'h0F, 6'h00, 0, 0, 0, 0);
        c = build("lw", 6'h23, 6'h00, 0, 0, 0, 0);
        chk("len_lw", c, 5);
        c = build("sw_w2", 6'h2B, 6'h00, 0, 1, 2, 0);

        // Memory never answers: four waiting cycles, bus_err on the fifth.
        for (int k = 0; k <= 4; k++) begin
            o = '0; o.req = 1; o.berr = (k == 4);
            push("tmo", 1, 6'h00, 6'h21, 0, 0, o);
        end
        for (int k = 0; k < 3; k++) begin
            o = '0; o.st = 10; o.halt = 1;
            push("halt", 1, 6'h00, 6'h21, 0, 1, o);
        end
        rst_cycles(2);

        // Reset lands in the middle of a MEM_WR wait.
        c = build("sw_rst", 6'h2B, 6'h00, 0, 0, 3, 0);
        void'(q.pop_back());
        void'(q.pop_back());
        rst_cycles(2);
        c = build("addu2", 6'h00, 6'h20, 0, 1, 0, 0);

        foreach (q[i]) begin
            @(negedge clk);
            rstn = q[i].rn; Op = q[i].op; Funct = q[i].fn;
            Zero = q[i].z; mif.mem_ack = q[i].ack;
            #1;
            act.st = state; act.req = mif.mem_req; act.iord = mif.IorD;
            act.mw = mif.MemWrite; act.irw = IRWrite; act.pcw = PCWrite;
            act.rw = RegWrite; act.ext = EXTOp; act.asa = ALUSrcA;
            act.asb = ALUSrcB; act.alu = ALUOp; act.npc = NPCOp;
            act.gsel = GPRSel; act.wd = WDSel; act.done = instr_done;
            act.ill = illegal; act.berr = bus_err; act.halt = halted;
            chk($sformatf("%s#%0d", q[i].tag, i), 32'(act), 32'(q[i].exp));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
